// File: rtl/cpu16_pkg.sv
// Shared CPU16 definitions: sequencer state encoding and default opcode values.
package cpu16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_REG_READ  = 3'd3,
    ST_ALU_OP    = 3'd4,
    ST_MEM       = 3'd5,
    ST_REG_WRITE = 3'd6,
    ST_HALT      = 3'd7
  } state_t;

  localparam int         OPCODE_W_DEF = 5;
  localparam logic [4:0] OP_LOAD_DEF  = 5'h10;
  localparam logic [4:0] OP_STORE_DEF = 5'h11;
  localparam logic [4:0] OP_HALT_DEF  = 5'h1F;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between the decoder/memory side and the multicycle sequencer.
interface multicycle_sequencer_if #(
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 16
);
  logic                I_run;
  logic                I_stall;
  logic [OPCODE_W-1:0] I_opcode;
  logic                I_mem_ready;
  logic                O_fetch_enable;
  logic                O_dec_enable;
  logic                O_reg_read_enable;
  logic                O_alu_enable;
  logic                O_mem_enable;
  logic                O_reg_write_enable;
  logic                O_pc_update;
  logic                O_halted;
  logic                O_error;
  logic [2:0]          O_state;
  logic [CNT_W-1:0]    O_instr_count;

  modport master (
    output I_run, I_stall, I_opcode, I_mem_ready,
    input  O_fetch_enable, O_dec_enable, O_reg_read_enable, O_alu_enable,
           O_mem_enable, O_reg_write_enable, O_pc_update, O_halted, O_error,
           O_state, O_instr_count
  );

  modport slave (
    input  I_run, I_stall, I_opcode, I_mem_ready,
    output O_fetch_enable, O_dec_enable, O_reg_read_enable, O_alu_enable,
           O_mem_enable, O_reg_write_enable, O_pc_update, O_halted, O_error,
           O_state, O_instr_count
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory handshake; flags a timeout
// on the MEM_WAIT_MAX-th consecutive not-ready cycle.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic I_clk,
  input  logic I_reset,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_timeout
);
  localparam int            LP_W  = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [LP_W-1:0] LP_TC = LP_W'(MEM_WAIT_MAX - 1);

  logic [LP_W-1:0] r_wait_cnt;
  logic            w_waiting;

  assign w_waiting = i_active && !i_mem_ready;
  assign o_timeout = w_waiting && (r_wait_cnt == LP_TC);

  // Leaving the waiting state (ready, timeout or inactive) always clears.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset)
      r_wait_cnt <= '0;
    else if (w_waiting && !o_timeout)
      r_wait_cnt <= r_wait_cnt + 1'b1;
    else
      r_wait_cnt <= '0;
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: walks FETCH..REG_WRITE per instruction,
// honours stalls in internal stages and halts on opcode or memory timeout.
module multicycle_sequencer
  import cpu16_pkg::*;
#(
  parameter int                  OPCODE_W     = OPCODE_W_DEF,
  parameter int                  CNT_W        = 16,
  parameter int                  MEM_WAIT_MAX = 15,
  parameter logic [OPCODE_W-1:0] OP_LOAD      = OPCODE_W'(OP_LOAD_DEF),
  parameter logic [OPCODE_W-1:0] OP_STORE     = OPCODE_W'(OP_STORE_DEF),
  parameter logic [OPCODE_W-1:0] OP_HALT      = OPCODE_W'(OP_HALT_DEF)
) (
  input  logic                    I_clk,
  input  logic                    I_reset,
  multicycle_sequencer_if.slave   bus
);
  state_t              r_state;
  state_t              w_next_state;
  logic [OPCODE_W-1:0] r_opcode;
  logic                r_error;
  logic [CNT_W-1:0]    r_instr_count;
  logic                w_timeout;
  logic                w_mem_active;
  logic                w_pc_update;
  logic                w_is_mem_op;

  assign w_mem_active = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_is_mem_op  = (r_opcode == OP_LOAD) || (r_opcode == OP_STORE);

  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
    .I_clk       (I_clk),
    .I_reset     (I_reset),
    .i_active    (w_mem_active),
    .i_mem_ready (bus.I_mem_ready),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (bus.I_run) w_next_state = ST_FETCH;
      ST_FETCH:     if (bus.I_mem_ready) w_next_state = ST_DECODE;
                    else if (w_timeout) w_next_state = ST_HALT;
      ST_DECODE:    if (!bus.I_stall)
                      w_next_state = (bus.I_opcode == OP_HALT) ? ST_HALT : ST_REG_READ;
      ST_REG_READ:  if (!bus.I_stall) w_next_state = ST_ALU_OP;
      ST_ALU_OP:    if (!bus.I_stall) w_next_state = w_is_mem_op ? ST_MEM : ST_REG_WRITE;
      ST_MEM:       if (bus.I_mem_ready)
                      w_next_state = (r_opcode == OP_LOAD) ? ST_REG_WRITE : ST_FETCH;
                    else if (w_timeout) w_next_state = ST_HALT;
      ST_REG_WRITE: if (!bus.I_stall) w_next_state = ST_FETCH;
      default:      w_next_state = r_state;
    endcase
  end

  // Stalled internal stages hold with their strobe low; the strobe fires on the leaving cycle.
  always_comb begin
    bus.O_fetch_enable     = 1'b0;
    bus.O_dec_enable       = 1'b0;
    bus.O_reg_read_enable  = 1'b0;
    bus.O_alu_enable       = 1'b0;
    bus.O_mem_enable       = 1'b0;
    bus.O_reg_write_enable = 1'b0;
    w_pc_update            = 1'b0;
    case (r_state)
      ST_FETCH:     bus.O_fetch_enable    = 1'b1;
      ST_DECODE:    bus.O_dec_enable      = !bus.I_stall;
      ST_REG_READ:  bus.O_reg_read_enable = !bus.I_stall;
      ST_ALU_OP:    bus.O_alu_enable      = !bus.I_stall;
      ST_MEM: begin
        bus.O_mem_enable = 1'b1;
        w_pc_update      = bus.I_mem_ready && (r_opcode != OP_LOAD);
      end
      ST_REG_WRITE: begin
        bus.O_reg_write_enable = !bus.I_stall;
        w_pc_update            = !bus.I_stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      r_opcode      <= '0;
      r_error       <= 1'b0;
      r_instr_count <= '0;
    end else begin
      if (r_state == ST_DECODE && !bus.I_stall) r_opcode <= bus.I_opcode;
      if (w_timeout) r_error <= 1'b1;
      if (w_pc_update) r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign bus.O_pc_update   = w_pc_update;
  assign bus.O_halted      = (r_state == ST_HALT);
  assign bus.O_error       = r_error;
  assign bus.O_state       = r_state;
  assign bus.O_instr_count = r_instr_count;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: ALU/load/store/halt flows, stalls,
// memory timeout boundary and mid-instruction reset.
module tb_multicycle_sequencer;
  logic I_clk = 1'b0;
  logic I_reset;
  int   checks = 0;
  int   failures = 0;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SF = 6'b100000;
  localparam logic [5:0] SD = 6'b010000;
  localparam logic [5:0] SR = 6'b001000;
  localparam logic [5:0] SA = 6'b000100;
  localparam logic [5:0] SM = 6'b000010;
  localparam logic [5:0] SW = 6'b000001;

  always #5 I_clk = ~I_clk;

  multicycle_sequencer_if #(.OPCODE_W(5), .CNT_W(16)) bus ();

  multicycle_sequencer dut (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .bus     (bus)
  );

  logic [5:0] strb;
  assign strb = {bus.O_fetch_enable, bus.O_dec_enable, bus.O_reg_read_enable,
                 bus.O_alu_enable, bus.O_mem_enable, bus.O_reg_write_enable};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle (state, strobes, retire pulse) then advance to the next.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] sb, input logic pc);
    #1;
    chk({tag, "_state"}, 32'(bus.O_state), 32'(st));
    chk({tag, "_strb"}, 32'(strb), 32'(sb));
    chk({tag, "_pc"}, 32'(bus.O_pc_update), 32'(pc));
    @(posedge I_clk);
    #2;
  endtask

  task automatic do_reset();
    I_reset         = 1'b1;
    bus.I_run       = 1'b0;
    bus.I_stall     = 1'b0;
    bus.I_opcode    = 5'h00;
    bus.I_mem_ready = 1'b0;
    @(posedge I_clk);
    #2;
    #1;
    chk("rst_state", 32'(bus.O_state), 32'd0);
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_count", 32'(bus.O_instr_count), 32'd0);
    chk("rst_err", 32'(bus.O_error), 32'd0);
    I_reset = 1'b0;
  endtask

  initial begin
    // ALU instruction, zero waits
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b1; bus.I_opcode = 5'h00;
    cyc("alu_idle", 3'd0, S0, 1'b0);
    cyc("alu_f", 3'd1, SF, 1'b0);
    cyc("alu_d", 3'd2, SD, 1'b0);
    cyc("alu_r", 3'd3, SR, 1'b0);
    cyc("alu_a", 3'd4, SA, 1'b0);
    cyc("alu_w", 3'd6, SW, 1'b1);
    #1;
    chk("alu_next", 32'(bus.O_state), 32'd1);
    chk("alu_count", 32'(bus.O_instr_count), 32'd1);

    // Load with 3 not-ready MEM cycles
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b1; bus.I_opcode = 5'h10;
    cyc("ld_idle", 3'd0, S0, 1'b0);
    cyc("ld_f", 3'd1, SF, 1'b0);
    cyc("ld_d", 3'd2, SD, 1'b0);
    cyc("ld_r", 3'd3, SR, 1'b0);
    cyc("ld_a", 3'd4, SA, 1'b0);
    bus.I_mem_ready = 1'b0;
    cyc("ld_m1", 3'd5, SM, 1'b0);
    cyc("ld_m2", 3'd5, SM, 1'b0);
    cyc("ld_m3", 3'd5, SM, 1'b0);
    bus.I_mem_ready = 1'b1;
    cyc("ld_m4", 3'd5, SM, 1'b0);
    cyc("ld_w", 3'd6, SW, 1'b1);
    #1;
    chk("ld_count", 32'(bus.O_instr_count), 32'd1);
    chk("ld_err", 32'(bus.O_error), 32'd0);

    // Store retires from MEM, no write-back
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b1; bus.I_opcode = 5'h11;
    cyc("st_idle", 3'd0, S0, 1'b0);
    cyc("st_f", 3'd1, SF, 1'b0);
    cyc("st_d", 3'd2, SD, 1'b0);
    cyc("st_r", 3'd3, SR, 1'b0);
    cyc("st_a", 3'd4, SA, 1'b0);
    cyc("st_m", 3'd5, SM, 1'b1);
    bus.I_mem_ready = 1'b0;
    cyc("st_f2", 3'd1, SF, 1'b0);
    #1;
    chk("st_count", 32'(bus.O_instr_count), 32'd1);

    // Two stall cycles in ALU_OP
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b1; bus.I_opcode = 5'h03;
    cyc("stl_idle", 3'd0, S0, 1'b0);
    cyc("stl_f", 3'd1, SF, 1'b0);
    cyc("stl_d", 3'd2, SD, 1'b0);
    cyc("stl_r", 3'd3, SR, 1'b0);
    bus.I_stall = 1'b1;
    cyc("stl_a1", 3'd4, S0, 1'b0);
    cyc("stl_a2", 3'd4, S0, 1'b0);
    bus.I_stall = 1'b0;
    cyc("stl_a3", 3'd4, SA, 1'b0);
    cyc("stl_w", 3'd6, SW, 1'b1);
    #1;
    chk("stl_count", 32'(bus.O_instr_count), 32'd1);

    // 15 not-ready FETCH cycles -> timeout halt
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b0;
    cyc("to_idle", 3'd0, S0, 1'b0);
    for (int i = 0; i < 15; i++) cyc("to_f", 3'd1, SF, 1'b0);
    #1;
    chk("to_state", 32'(bus.O_state), 32'd7);
    chk("to_err", 32'(bus.O_error), 32'd1);
    chk("to_halted", 32'(bus.O_halted), 32'd1);
    chk("to_strb", 32'(strb), 32'd0);
    bus.I_mem_ready = 1'b1;
    cyc("to_hold", 3'd7, S0, 1'b0);

    // Ready arrives on the 15th cycle -> success
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b0;
    cyc("ok_idle", 3'd0, S0, 1'b0);
    for (int i = 0; i < 14; i++) cyc("ok_f", 3'd1, SF, 1'b0);
    bus.I_mem_ready = 1'b1;
    cyc("ok_f15", 3'd1, SF, 1'b0);
    #1;
    chk("ok_state", 32'(bus.O_state), 32'd2);
    chk("ok_err", 32'(bus.O_error), 32'd0);

    // Halt opcode
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b1; bus.I_opcode = 5'h1F;
    cyc("h_idle", 3'd0, S0, 1'b0);
    cyc("h_f", 3'd1, SF, 1'b0);
    cyc("h_d", 3'd2, SD, 1'b0);
    #1;
    chk("h_state", 32'(bus.O_state), 32'd7);
    chk("h_halted", 32'(bus.O_halted), 32'd1);
    chk("h_err", 32'(bus.O_error), 32'd0);
    chk("h_count", 32'(bus.O_instr_count), 32'd0);

    // Reset mid REG_READ
    do_reset();
    bus.I_run = 1'b1; bus.I_mem_ready = 1'b1; bus.I_opcode = 5'h00;
    cyc("mr_idle", 3'd0, S0, 1'b0);
    cyc("mr_f", 3'd1, SF, 1'b0);
    cyc("mr_d", 3'd2, SD, 1'b0);
    #1;
    chk("mr_rd", 32'(bus.O_state), 32'd3);
    I_reset = 1'b1;
    #1;
    chk("mr_state", 32'(bus.O_state), 32'd0);
    chk("mr_strb", 32'(strb), 32'd0);
    chk("mr_pc", 32'(bus.O_pc_update), 32'd0);
    chk("mr_count", 32'(bus.O_instr_count), 32'd0);
    chk("mr_halted", 32'(bus.O_halted), 32'd0);
    @(posedge I_clk);
    #2;
    I_reset = 1'b0;
    bus.I_run = 1'b0;
    cyc("mr_hold1", 3'd0, S0, 1'b0);
    cyc("mr_hold2", 3'd0, S0, 1'b0);
    bus.I_run = 1'b1;
    cyc("mr_go", 3'd0, S0, 1'b0);
    #1;
    chk("mr_fetch", 32'(bus.O_state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameters: OPCODE_W, default 5, opcode width; CNT_W, default 16, retired-instruction counter width; MEM_WAIT_MAX, default 15, consecutive not-ready cycles that trigger a timeout; OP_LOAD, default 5'h10, load opcode; OP_STORE, default 5'h11, store opcode; OP_HALT, default 5'h1F, halt opcode.
REQ-002 SHALL have ports: I_clk in 1 clock; I_reset in 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports: I_run in 1 start from IDLE; I_stall in 1 freeze request; I_opcode in OPCODE_W opcode from the decoder; I_mem_ready in 1 memory handshake completion.
REQ-004 SHALL have ports: O_fetch_enable, O_dec_enable, O_reg_read_enable, O_alu_enable, O_mem_enable, O_reg_write_enable, each out 1, stage strobes.
REQ-005 SHALL have ports: O_pc_update out 1 retire pulse; O_halted out 1; O_error out 1 sticky timeout flag; O_state out 3 current state; O_instr_count out CNT_W retired instructions.

Function
REQ-006 SHALL implement states IDLE, FETCH, DECODE, REG_READ, ALU_OP, MEM, REG_WRITE, HALT.
REQ-007 SHALL move from IDLE to FETCH on I_run=1; IDLE SHALL hold otherwise.
REQ-008 SHALL hold FETCH and assert O_fetch_enable every FETCH cycle; SHALL advance to DECODE on the cycle I_mem_ready=1.
REQ-009 SHALL sample I_opcode into an internal register in the first non-stalled DECODE cycle; opcode OP_HALT SHALL go to HALT; all other opcodes SHALL go to REG_READ.
REQ-010 SHALL sequence REG_READ to ALU_OP; from ALU_OP, load and store SHALL go to MEM and all other opcodes SHALL go to REG_WRITE.
REQ-011 SHALL hold MEM with O_mem_enable asserted until I_mem_ready=1; then load SHALL go to REG_WRITE and store SHALL go to FETCH.
REQ-012 SHALL go from REG_WRITE to FETCH.
REQ-013 SHALL treat I_stall=1 in DECODE, REG_READ, ALU_OP or REG_WRITE as follows: state held, that state's strobe deasserted; the strobe is a single-cycle pulse on the first non-stalled cycle.
REQ-014 SHALL ignore I_stall in IDLE, FETCH, MEM and HALT, where the memory handshake has priority.
REQ-015 SHALL keep strobes one-hot or all-zero; no strobe SHALL be asserted in IDLE or HALT.
REQ-016 SHALL pulse O_pc_update for one cycle on the cycle the state leaves REG_WRITE, or leaves MEM for a store, and increment O_instr_count on that same edge.
REQ-017 SHALL wrap O_instr_count modulo 2^CNT_W.
REQ-018 SHALL keep a wait counter that increments on each FETCH or MEM cycle with I_mem_ready=0 and clears on I_mem_ready=1 or on any state change.
REQ-019 SHALL, when the wait counter equals MEM_WAIT_MAX-1 and I_mem_ready=0, go to HALT next cycle and set O_error; I_mem_ready=1 in that cycle SHALL count as success.
REQ-020 SHALL hold O_halted=1 in HALT; HALT SHALL exit only via reset.
REQ-021 SHALL drive O_state with the encoding 0..7, in the order of REQ-006.
REQ-022 SHALL give an ALU-class instruction a latency of 5 cycles (FETCH through REG_WRITE) with zero wait states and no stalls; load 6; store 5.

Reset
REQ-023 SHALL, while I_reset=1, force IDLE, all strobes 0, O_pc_update 0, O_halted 0, O_error 0, O_instr_count 0, wait counter 0 and latched opcode 0, immediately and regardless of state.
REQ-024 SHALL abandon an in-flight instruction on reset mid-instruction without a retire pulse; the sequencer SHALL remain in IDLE after release until I_run=1.

Structure
REQ-025 SHALL take the state encodings and default opcode constants from the shared package cpu16_pkg.
REQ-026 SHALL implement the wait counter and timeout compare as sub-module mem_wait_timer, parametrised by MEM_WAIT_MAX.

Verification
REQ-027 SHALL verify: reset, I_run=1, opcode 5'h00, I_mem_ready=1 constantly -> strobes fetch, dec, rd, alu, wb on consecutive cycles; O_pc_update on cycle 5; O_instr_count=1.
REQ-028 SHALL verify: opcode 5'h10, MEM held not-ready 3 cycles -> O_mem_enable high 4 cycles, then REG_WRITE, O_instr_count increments.
REQ-029 SHALL verify: opcode 5'h11 -> MEM directly to FETCH with no O_reg_write_enable and one O_pc_update.
REQ-030 SHALL verify: I_stall=1 for 2 cycles during ALU_OP -> O_alu_enable a single pulse after release, total latency 7.
REQ-031 SHALL verify: I_mem_ready=0 for 15 cycles in FETCH -> HALT, O_error=1, O_halted=1; a ready on cycle 15 instead -> DECODE, no error.
REQ-032 SHALL verify: opcode 5'h1F -> HALT after DECODE; I_reset pulse mid-REG_READ -> IDLE, all outputs 0, count unchanged from the prior value 0.
